// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NCH independent 50% dividers with
// glitch-free (shadowed) divisor updates. Define SYNC_EN to add the phase-realign input.
module clk_div_multi #(
  parameter  int NCH     = 4,
  parameter  int CW      = 12,
  parameter  int DEF_DIV = 2500,
  localparam int WCH     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [WCH-1:0] wr_ch,
  input  logic [CW-1:0]  wr_div,
`ifdef SYNC_EN
  input  logic           sync,
`endif
  input  logic [NCH-1:0] ch_en,
  output logic [NCH-1:0] clk_div,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
);

  localparam logic [CW-1:0] DEF_VAL = CW'(DEF_DIV);

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  act_q [NCH];
  logic [CW-1:0]  act_d [NCH];
  logic [CW-1:0]  shd_q [NCH];
  logic [CW-1:0]  shd_d [NCH];
  logic [NCH-1:0] clk_q, clk_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] pend_q, pend_d;

  always_comb begin
    // NOTE: every next-state signal gets a hold/default value first so no path leaves it unassigned (no latch).
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    clk_d  = clk_q;
    pend_d = pend_q;
    tick_d = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef SYNC_EN
      if (sync) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (pend_q[i]) begin
          act_d[i]  = shd_q[i];
          pend_d[i] = 1'b0;
        end
      end else
`endif
      if (ch_en[i]) begin
        if (cnt_q[i] == act_q[i]) begin
          cnt_d[i]  = '0;
          clk_d[i]  = ~clk_q[i];
          tick_d[i] = 1'b1;
          // The wrap consumes the shadow as it stood before this edge's write.
          if (pend_q[i]) begin
            act_d[i]  = shd_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      // Written last so a same-cycle write re-arms pend after a wrap clears it.
      if (wr_en && (32'(wr_ch) == i)) begin
        shd_d[i]  = wr_div;
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the per-channel arrays are real control state, so they are reset like any register.
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= DEF_VAL;
        shd_q[i] <= DEF_VAL;
      end
      clk_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see the pre-edge values.
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign clk_div = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi: a default 4-channel instance and a
// small 6-channel instance (DEF_DIV=7) for write-range and wrap/write collision cases.
module tb_clk_div_multi;

  localparam int NCH  = 4;
  localparam int CW   = 12;
  localparam int NCH6 = 6;
  localparam int CW6  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            wr_en;
  logic [1:0]      wr_ch;
  logic [CW-1:0]   wr_div;
  logic [NCH-1:0]  ch_en;
  logic [NCH-1:0]  clk_div, tick, pend;

  logic            reset6;
  logic            wr_en6;
  logic [2:0]      wr_ch6;
  logic [CW6-1:0]  wr_div6;
  logic [NCH6-1:0] ch_en6;
  logic [NCH6-1:0] clk_div6, tick6, pend6;

  int checks   = 0;
  int failures = 0;
  int ecount   = 0;

  clk_div_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(2500)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
`ifdef SYNC_EN
    .sync    (1'b0),
`endif
    .ch_en   (ch_en),
    .clk_div (clk_div),
    .tick    (tick),
    .pend    (pend)
  );

  clk_div_multi #(.NCH(NCH6), .CW(CW6), .DEF_DIV(7)) u_dut6 (
    .clk     (clk),
    .reset   (reset6),
    .wr_en   (wr_en6),
    .wr_ch   (wr_ch6),
    .wr_div  (wr_div6),
`ifdef SYNC_EN
    .sync    (1'b0),
`endif
    .ch_en   (ch_en6),
    .clk_div (clk_div6),
    .tick    (tick6),
    .pend    (pend6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  // Advance to edge e after the latest reset release; samples land 1 ns after the edge.
  task automatic run_to(input int e);
    while (ecount < e) begin
      @(posedge clk);
      #1;
      ecount++;
    end
  endtask

  task automatic release_main();
    @(posedge clk);
    #1;
    reset  = 1'b1;
    ecount = 0;
  endtask

  initial begin
    int   rise_e, fall_e, tick_n, tick_a, tick_b, hi_bad;
    logic prev, c1, c2, t1;

    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_div  = '0;
    ch_en   = 4'b0001;
    reset6  = 1'b0;
    wr_en6  = 1'b0;
    wr_ch6  = '0;
    wr_div6 = '0;
    ch_en6  = 6'h3F;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 32'({clk_div, tick, pend}), 32'd0);
    check("rst_outputs6", 32'({clk_div6, tick6, pend6}), 32'd0);

    // T1: first rise on edge 2501, fall on edge 5002, tick only on those edges
    release_main();
    rise_e = 0; fall_e = 0; tick_n = 0; tick_a = 0; tick_b = 0; hi_bad = 0; prev = 1'b0;
    for (int e = 1; e <= 5003; e++) begin
      run_to(e);
      if (tick[0]) begin
        tick_n++;
        if (tick_n == 1) tick_a = e;
        else tick_b = e;
      end
      if (clk_div[0] && !prev) rise_e = e;
      if (!clk_div[0] && prev) fall_e = e;
      prev = clk_div[0];
      if (clk_div[3:1] != 3'b000 || tick[3:1] != 3'b000) hi_bad++;
    end
    check("t1_rise_edge", 32'(rise_e), 32'd2501);
    check("t1_fall_edge", 32'(fall_e), 32'd5002);
    check("t1_tick_count", 32'(tick_n), 32'd2);
    check("t1_tick_first", 32'(tick_a), 32'd2501);
    check("t1_tick_second", 32'(tick_b), 32'd5002);
    check("t1_idle_channels", 32'(hi_bad), 32'd0);
    check("t1_pend", 32'(pend), 32'd0);

    // T2/T3: shadow writes to ch1 (div 3) and ch2 (div 0) mid-period
    #2;
    reset = 1'b0;
    ch_en = 4'b0110;
    release_main();
    run_to(10);
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 12'd3;
    run_to(11);
    check("t2_pend_ch1", 32'(pend), 32'b0010);
    wr_ch = 2'd2; wr_div = 12'd0;
    run_to(12);
    wr_en = 1'b0;
    check("t2_pend_both", 32'(pend), 32'b0110);
    run_to(2500);
    check("t2_before_wrap", 32'({clk_div, pend}), 32'b0000_0110);
    run_to(2501);
    check("t2_wrap", 32'({clk_div, tick, pend}), 32'b0110_0110_0000);
    c1 = 1'b1; c2 = 1'b1;
    for (int e = 2502; e <= 2517; e++) begin
      run_to(e);
      t1 = ((e - 2501) % 4) == 0;
      if (t1) c1 = ~c1;
      c2 = ~c2;
      check("t23_fast_channels", 32'({clk_div[2], clk_div[1], tick[2], tick[1]}),
            32'({c2, c1, 1'b1, t1}));
    end

    // T6: asynchronous reset mid-count, between clock edges
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_clear", 32'({clk_div, tick, pend}), 32'd0);

    // T4: hold ch0 for 100 cycles at cnt=1000, with a write landing during the hold
    ch_en = 4'b0001;
    release_main();
    run_to(1000);
    ch_en = 4'b0000;
    run_to(1050);
    check("t4_hold_outputs", 32'({clk_div, tick}), 32'd0);
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 12'd4;
    run_to(1051);
    wr_en = 1'b0;
    run_to(1100);
    check("t4_hold_pend", 32'({tick, pend}), 32'b0000_0001);
    ch_en = 4'b0001;
    run_to(2600);
    check("t4_before_toggle", 32'({clk_div, pend}), 32'b0000_0001);
    run_to(2601);
    check("t4_toggle", 32'({clk_div, tick, pend}), 32'b0001_0001_0000);
    run_to(2605);
    check("t4_new_div_mid", 32'({clk_div, tick}), 32'b0001_0000);
    run_to(2606);
    check("t4_new_div_wrap", 32'({clk_div, tick}), 32'b0000_0001);

    // T5: 6-channel instance, DEF_DIV=7 -> wraps on edges 8, 16, 24, ...
    @(posedge clk);
    #1;
    reset6 = 1'b1;
    ecount = 0;
    run_to(2);
    wr_en6 = 1'b1; wr_ch6 = 3'd7; wr_div6 = 4'd1;
    run_to(3);
    check("t5_out_of_range", 32'(pend6), 32'd0);
    wr_ch6 = 3'd5; wr_div6 = 4'd2;
    run_to(4);
    wr_en6 = 1'b0;
    check("t5_last_valid_ch", 32'(pend6), 32'b100000);
    run_to(8);
    check("t5_first_wrap", 32'({clk_div6, tick6, pend6}), 32'b111111_111111_000000);
    run_to(11);
    check("t5_ch5_new_div", 32'({clk_div6, tick6}), 32'b011111_100000);
    run_to(15);
    wr_en6 = 1'b1; wr_ch6 = 3'd0; wr_div6 = 4'd3;
    run_to(16);
    check("t5_write_at_wrap", 32'({tick6, pend6}), 32'b011111_000001);
    wr_ch6 = 3'd1; wr_div6 = 4'd1;
    run_to(17);
    wr_div6 = 4'd2;
    run_to(18);
    wr_en6 = 1'b0;
    check("t5_pend_two", 32'(pend6), 32'b000011);
    run_to(23);
    check("t5_still_pending", 32'({tick6[0], pend6}), 32'b0_000011);
    run_to(24);
    check("t5_old_shadow_wrap", 32'({tick6, pend6}), 32'b011111_000000);
    run_to(26);
    check("t5_ch5_period", 32'(tick6), 32'b100000);
    run_to(27);
    check("t5_back_to_back", 32'(tick6), 32'b000010);
    run_to(28);
    check("t5_applied_late", 32'(tick6), 32'b000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
